// File: rtl/clk_step_ctrl.sv
// clk_step_ctrl
// Debug clock-step controller sitting directly upstream of clk_count_stop.
// The host issues HALT / RUN / STEP / CLEAR commands over a valid/ready
// handshake; the controller drives clk_count_stop's active and trg_count
// inputs, watches its match output, and keeps a mirror of executed gated
// clock cycles so the host can free-run, halt, or single/multi-step.
//
// Ports:
//   clk_in       free-running system clock (ungated side)
//   rst          synchronous reset, active-high
//   cmd_valid    command present
//   cmd_ready    command accepted on an edge with cmd_valid & cmd_ready
//   cmd_op       00 HALT, 01 RUN, 10 STEP, 11 CLEAR
//   cmd_arg      step count N (STEP only), zero-extended to CNT_W
//   match        from clk_count_stop, gated clock reached trg_count
//   active       to clk_count_stop
//   trg_count    to clk_count_stop, absolute cycle target
//   cycle_count  executed gated-clock cycles
//   halted       high while in HALT
//   step_done    one-cycle pulse when a STEP or HALT request completes
//
// Optional feature (macro CLK_STEP_BRK_EN):
//   brk_en       breakpoint enable
//   brk_count    breakpoint cycle; FREE halts so that cycle_count == brk_count
//   brk_hit      pulses together with step_done when a breakpoint halt completes

module clk_step_ctrl #(
    parameter int CNT_W = 64,
    parameter int ARG_W = 32
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [ARG_W-1:0] cmd_arg,
    input  logic             match,
    output logic             active,
    output logic [CNT_W-1:0] trg_count,
    output logic [CNT_W-1:0] cycle_count,
    output logic             halted,
    output logic             step_done
`ifdef CLK_STEP_BRK_EN
    ,
    input  logic             brk_en,
    input  logic [CNT_W-1:0] brk_count,
    output logic             brk_hit
`endif
);

    typedef enum logic [1:0] {
        ST_FREE = 2'd0,
        ST_STEP = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam logic [1:0] OP_HALT  = 2'b00;
    localparam logic [1:0] OP_RUN   = 2'b01;
    localparam logic [1:0] OP_STEP  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic             active_q, active_d;
    logic [CNT_W-1:0] trg_q, trg_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic             done_q, done_d;

    logic             cmdFire;
    logic [CNT_W-1:0] argExt;

`ifdef CLK_STEP_BRK_EN
    logic             brkPend_q, brkPend_d;
    logic             brkHit_q, brkHit_d;
    logic             breakFire;
`endif

    // Ready depends on state only so the handshake never loops through cmd_valid.
    assign cmdFire = cmd_valid & cmd_ready;
    assign argExt  = CNT_W'(cmd_arg);

`ifdef CLK_STEP_BRK_EN
    // Arming one cycle early means the halt lands with cycle_count == brk_count.
    assign breakFire = brk_en && (cyc_q == (brk_count - ONE));
`endif

    // Next-state and next-output logic; every register holds unless changed.
    always_comb begin
        state_d  = state_q;
        active_d = active_q;
        trg_d    = trg_q;
        cyc_d    = cyc_q;
        done_d   = 1'b0;
`ifdef CLK_STEP_BRK_EN
        brkPend_d = brkPend_q;
        brkHit_d  = 1'b0;
`endif
        case (state_q)
            ST_FREE: begin
                // Downstream clock is ungated here, so every edge is a cycle.
                cyc_d    = cyc_q + ONE;
                active_d = 1'b0;
                if (cmdFire) begin
                    case (cmd_op)
                        OP_HALT: begin
                            trg_d    = cyc_q + ONE;
                            active_d = 1'b1;
                            state_d  = ST_STEP;
                        end
                        OP_STEP: begin
                            trg_d    = cyc_q + argExt;
                            active_d = 1'b1;
                            state_d  = ST_STEP;
                        end
                        default: ;
                    endcase
                end
`ifdef CLK_STEP_BRK_EN
                else if (breakFire) begin
                    trg_d     = cyc_q + ONE;
                    active_d  = 1'b1;
                    state_d   = ST_STEP;
                    brkPend_d = 1'b1;
                end
`endif
            end
            ST_STEP: begin
                // A match on the first STEP cycle completes without counting.
                if (match) begin
                    state_d = ST_HALT;
                    done_d  = 1'b1;
`ifdef CLK_STEP_BRK_EN
                    brkHit_d  = brkPend_q;
                    brkPend_d = 1'b0;
`endif
                end else begin
                    cyc_d = cyc_q + ONE;
                end
            end
            ST_HALT: begin
                if (cmdFire) begin
                    case (cmd_op)
                        OP_STEP: begin
                            // A zero-length step completes immediately in place.
                            if (argExt != '0) begin
                                trg_d   = trg_q + argExt;
                                state_d = ST_STEP;
                            end else begin
                                done_d = 1'b1;
                            end
                        end
                        OP_RUN: begin
                            active_d = 1'b0;
                            state_d  = ST_FREE;
                        end
                        OP_CLEAR: begin
                            cyc_d = '0;
                            trg_d = '0;
                        end
                        default: ;
                    endcase
                end
            end
            default: begin
                state_d  = ST_FREE;
                active_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset back to FREE.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q  <= ST_FREE;
            active_q <= 1'b0;
            trg_q    <= '0;
            cyc_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
            trg_q    <= trg_d;
            cyc_q    <= cyc_d;
            done_q   <= done_d;
        end
    end

`ifdef CLK_STEP_BRK_EN
    // Breakpoint bookkeeping: remember that the current STEP came from a breakpoint.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            brkPend_q <= 1'b0;
            brkHit_q  <= 1'b0;
        end else begin
            brkPend_q <= brkPend_d;
            brkHit_q  <= brkHit_d;
        end
    end

    assign brk_hit = brkHit_q;
`endif

    assign cmd_ready   = (state_q != ST_STEP);
    assign active      = active_q;
    assign trg_count   = trg_q;
    assign cycle_count = cyc_q;
    assign halted      = (state_q == ST_HALT);
    assign step_done   = done_q;

endmodule

// File: tb/tb_clk_step_ctrl.sv
// tb_clk_step_ctrl
// Directed, table-driven bench for clk_step_ctrl. A second, 8-bit instance
// shares the command bus so target wrap-around can be reached in a few
// hundred cycles. The downstream clk_count_stop is modelled as a match that
// is high whenever the gated count equals the target while active.

module tb_clk_step_ctrl;

    localparam logic [1:0] OP_HALT  = 2'b00;
    localparam logic [1:0] OP_RUN   = 2'b01;
    localparam logic [1:0] OP_STEP  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    logic        clkIn = 1'b0;
    logic        rst;
    logic        cmdValid;
    logic [1:0]  cmdOp;
    logic [31:0] cmdArg;

    logic        cmdReady, active, halted, stepDone, match;
    logic [63:0] trgCount, cycleCount;

    logic        cmdReadyS, activeS, haltedS, stepDoneS, matchS;
    logic [7:0]  trgCountS, cycleCountS;

`ifdef CLK_STEP_BRK_EN
    logic        brkEn;
    logic [63:0] brkCount;
    logic        brkHit, brkHitS;
`endif

    int testCount = 0;
    int failCount = 0;

    typedef struct {
        logic        valid;
        logic [1:0]  op;
        logic [31:0] arg;
        logic        eActive;
        logic [63:0] eTrg;
        logic [63:0] eCyc;
        logic        eHalted;
        logic        eDone;
        logic        eReady;
    } vec_t;

    vec_t vecs[$];

    always #5 clkIn = ~clkIn;

    // Downstream model: gated count reaches the target while the gate is active.
    assign match  = active && (cycleCount == trgCount);
    assign matchS = activeS && (cycleCountS == trgCountS);

    clk_step_ctrl #(.CNT_W(64), .ARG_W(32)) dut (
        .clk_in      (clkIn),
        .rst         (rst),
        .cmd_valid   (cmdValid),
        .cmd_ready   (cmdReady),
        .cmd_op      (cmdOp),
        .cmd_arg     (cmdArg),
        .match       (match),
        .active      (active),
        .trg_count   (trgCount),
        .cycle_count (cycleCount),
        .halted      (halted),
        .step_done   (stepDone)
`ifdef CLK_STEP_BRK_EN
        ,
        .brk_en      (brkEn),
        .brk_count   (brkCount),
        .brk_hit     (brkHit)
`endif
    );

    clk_step_ctrl #(.CNT_W(8), .ARG_W(8)) dutSmall (
        .clk_in      (clkIn),
        .rst         (rst),
        .cmd_valid   (cmdValid),
        .cmd_ready   (cmdReadyS),
        .cmd_op      (cmdOp),
        .cmd_arg     (cmdArg[7:0]),
        .match       (matchS),
        .active      (activeS),
        .trg_count   (trgCountS),
        .cycle_count (cycleCountS),
        .halted      (haltedS),
        .step_done   (stepDoneS)
`ifdef CLK_STEP_BRK_EN
        ,
        .brk_en      (1'b0),
        .brk_count   (8'd0),
        .brk_hit     (brkHitS)
`endif
    );

    // Drive one command (or idle) and advance past the next rising edge.
    task automatic applyStimulus(input logic valid, input logic [1:0] op, input logic [31:0] arg);
        cmdValid = valid;
        cmdOp    = op;
        cmdArg   = arg;
        @(posedge clkIn);
        #1;
    endtask

    task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
        testCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input vec_t v);
        checkVal({tag, ".active"}, 64'(active), 64'(v.eActive));
        checkVal({tag, ".trg"}, trgCount, v.eTrg);
        checkVal({tag, ".cyc"}, cycleCount, v.eCyc);
        checkVal({tag, ".halted"}, 64'(halted), 64'(v.eHalted));
        checkVal({tag, ".done"}, 64'(stepDone), 64'(v.eDone));
        checkVal({tag, ".ready"}, 64'(cmdReady), 64'(v.eReady));
    endtask

    // Idle until the main DUT reports HALT, bounded by a cycle budget.
    task automatic waitHalted(input string tag, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            applyStimulus(1'b0, OP_HALT, 32'd0);
            if (halted) begin
                ok = 1'b1;
                break;
            end
        end
        checkVal({tag, ".reached"}, 64'(ok), 64'd1);
    endtask

    initial begin
        vec_t v;

        //                 valid op        arg     act trg      cyc      hlt done rdy
        vecs.push_back(vec_t'{1'b1, OP_HALT,  32'd0,   1'b1, 64'd11,  64'd11,  1'b0, 1'b0, 1'b0});
        vecs.push_back(vec_t'{1'b0, OP_HALT,  32'd0,   1'b1, 64'd11,  64'd11,  1'b1, 1'b1, 1'b1});
        vecs.push_back(vec_t'{1'b0, OP_HALT,  32'd0,   1'b1, 64'd11,  64'd11,  1'b1, 1'b0, 1'b1});
        vecs.push_back(vec_t'{1'b1, OP_STEP,  32'd5,   1'b1, 64'd16,  64'd11,  1'b0, 1'b0, 1'b0});
        vecs.push_back(vec_t'{1'b0, OP_HALT,  32'd0,   1'b1, 64'd16,  64'd12,  1'b0, 1'b0, 1'b0});
        vecs.push_back(vec_t'{1'b0, OP_HALT,  32'd0,   1'b1, 64'd16,  64'd13,  1'b0, 1'b0, 1'b0});
        vecs.push_back(vec_t'{1'b0, OP_HALT,  32'd0,   1'b1, 64'd16,  64'd14,  1'b0, 1'b0, 1'b0});
        vecs.push_back(vec_t'{1'b0, OP_HALT,  32'd0,   1'b1, 64'd16,  64'd15,  1'b0, 1'b0, 1'b0});
        vecs.push_back(vec_t'{1'b0, OP_HALT,  32'd0,   1'b1, 64'd16,  64'd16,  1'b0, 1'b0, 1'b0});
        vecs.push_back(vec_t'{1'b0, OP_HALT,  32'd0,   1'b1, 64'd16,  64'd16,  1'b1, 1'b1, 1'b1});
        vecs.push_back(vec_t'{1'b1, OP_STEP,  32'd0,   1'b1, 64'd16,  64'd16,  1'b1, 1'b1, 1'b1});
        vecs.push_back(vec_t'{1'b0, OP_HALT,  32'd0,   1'b1, 64'd16,  64'd16,  1'b1, 1'b0, 1'b1});
        vecs.push_back(vec_t'{1'b1, OP_STEP,  32'd2,   1'b1, 64'd18,  64'd16,  1'b0, 1'b0, 1'b0});
        vecs.push_back(vec_t'{1'b1, OP_RUN,   32'd0,   1'b1, 64'd18,  64'd17,  1'b0, 1'b0, 1'b0});
        vecs.push_back(vec_t'{1'b1, OP_RUN,   32'd0,   1'b1, 64'd18,  64'd18,  1'b0, 1'b0, 1'b0});
        vecs.push_back(vec_t'{1'b1, OP_RUN,   32'd0,   1'b1, 64'd18,  64'd18,  1'b1, 1'b1, 1'b1});
        vecs.push_back(vec_t'{1'b1, OP_RUN,   32'd0,   1'b0, 64'd18,  64'd18,  1'b0, 1'b0, 1'b1});
        vecs.push_back(vec_t'{1'b0, OP_HALT,  32'd0,   1'b0, 64'd18,  64'd19,  1'b0, 1'b0, 1'b1});
        vecs.push_back(vec_t'{1'b1, OP_CLEAR, 32'd0,   1'b0, 64'd18,  64'd20,  1'b0, 1'b0, 1'b1});
        vecs.push_back(vec_t'{1'b1, OP_HALT,  32'd0,   1'b1, 64'd21,  64'd21,  1'b0, 1'b0, 1'b0});
        vecs.push_back(vec_t'{1'b0, OP_HALT,  32'd0,   1'b1, 64'd21,  64'd21,  1'b1, 1'b1, 1'b1});
        vecs.push_back(vec_t'{1'b1, OP_CLEAR, 32'd0,   1'b1, 64'd0,   64'd0,   1'b1, 1'b0, 1'b1});
        vecs.push_back(vec_t'{1'b1, OP_HALT,  32'd0,   1'b1, 64'd0,   64'd0,   1'b1, 1'b0, 1'b1});
        vecs.push_back(vec_t'{1'b1, OP_RUN,   32'd0,   1'b0, 64'd0,   64'd0,   1'b0, 1'b0, 1'b1});
        vecs.push_back(vec_t'{1'b1, OP_STEP,  32'd100, 1'b1, 64'd100, 64'd1,   1'b0, 1'b0, 1'b0});
        vecs.push_back(vec_t'{1'b0, OP_HALT,  32'd0,   1'b1, 64'd100, 64'd2,   1'b0, 1'b0, 1'b0});
        vecs.push_back(vec_t'{1'b0, OP_HALT,  32'd0,   1'b1, 64'd100, 64'd3,   1'b0, 1'b0, 1'b0});

        rst      = 1'b1;
        cmdValid = 1'b0;
        cmdOp    = OP_HALT;
        cmdArg   = 32'd0;
`ifdef CLK_STEP_BRK_EN
        brkEn    = 1'b0;
        brkCount = 64'd0;
`endif
        @(posedge clkIn);
        #1;
        applyStimulus(1'b0, OP_HALT, 32'd0);
        checkOutput("reset", vec_t'{1'b0, OP_HALT, 32'd0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1});
        rst = 1'b0;

        for (int i = 0; i < 10; i++) applyStimulus(1'b0, OP_HALT, 32'd0);
        checkOutput("idle10", vec_t'{1'b0, OP_HALT, 32'd0, 1'b0, 64'd0, 64'd10, 1'b0, 1'b0, 1'b1});
        checkVal("idle10.trg", trgCount, 64'd0);

        // Main table: halt, step, zero step, held RUN, clear, start of a long step.
        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            applyStimulus(v.valid, v.op, v.arg);
            checkOutput($sformatf("vec%0d", i), v);
        end

        // Reset lands mid-STEP; the following edge is back in FREE.
        rst = 1'b1;
        applyStimulus(1'b0, OP_HALT, 32'd0);
        rst = 1'b0;
        checkOutput("rstStep", vec_t'{1'b0, OP_HALT, 32'd0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1});
        applyStimulus(1'b0, OP_HALT, 32'd0);
        checkOutput("rstStep.next", vec_t'{1'b0, OP_HALT, 32'd0, 1'b0, 64'd0, 64'd1, 1'b0, 1'b0, 1'b1});

        // Wrap: the 8-bit instance reaches target 253 = 2^8-3, then steps by 5.
        rst = 1'b1;
        applyStimulus(1'b0, OP_HALT, 32'd0);
        rst = 1'b0;
        applyStimulus(1'b1, OP_STEP, 32'd253);
        checkVal("wrap.trg0", 64'(trgCountS), 64'd253);
        waitHalted("wrap.first", 400);
        checkVal("wrap.cycS0", 64'(cycleCountS), 64'd253);
        checkVal("wrap.haltS0", 64'(haltedS), 64'd1);
        applyStimulus(1'b1, OP_STEP, 32'd5);
        checkVal("wrap.trgS", 64'(trgCountS), 64'd2);
        checkVal("wrap.trg64", trgCount, 64'd258);
        checkVal("wrap.readyS", 64'(cmdReadyS), 64'd0);
        waitHalted("wrap.second", 20);
        checkVal("wrap.cycS", 64'(cycleCountS), 64'd2);
        checkVal("wrap.doneS", 64'(stepDoneS), 64'd1);
        checkVal("wrap.cyc64", cycleCount, 64'd258);
        applyStimulus(1'b1, OP_CLEAR, 32'd0);
        checkVal("clear.trgS", 64'(trgCountS), 64'd0);
        checkVal("clear.cycS", 64'(cycleCountS), 64'd0);
        checkVal("clear.haltS", 64'(haltedS), 64'd1);

`ifdef CLK_STEP_BRK_EN
        // Breakpoint at cycle 20 from reset, then confirm it stays quiet when disabled.
        rst      = 1'b1;
        brkEn    = 1'b1;
        brkCount = 64'd20;
        applyStimulus(1'b0, OP_HALT, 32'd0);
        rst = 1'b0;
        waitHalted("brk", 60);
        checkVal("brk.cyc", cycleCount, 64'd20);
        checkVal("brk.hit", 64'(brkHit), 64'd1);
        checkVal("brk.done", 64'(stepDone), 64'd1);
        applyStimulus(1'b0, OP_HALT, 32'd0);
        checkVal("brk.hitPulse", 64'(brkHit), 64'd0);
        rst   = 1'b1;
        brkEn = 1'b0;
        applyStimulus(1'b0, OP_HALT, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 30; i++) applyStimulus(1'b0, OP_HALT, 32'd0);
        checkVal("brkOff.halted", 64'(halted), 64'd0);
        checkVal("brkOff.cyc", cycleCount, 64'd30);
`endif

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/clk_step_ctrl.md
# clk_step_ctrl

Debug clock-step controller that sits directly upstream of `clk_count_stop`. It accepts halt, run, step and clear commands over a valid/ready handshake. It drives `clk_count_stop`'s `active` and `trg_count` inputs and consumes its `match` output. It keeps a 64-bit mirror of executed system cycles so the host can free-run, halt, or single/multi-step the gated NES clock.

## Interface
Parameters:
- `CNT_W`, default 64: width of the `cycle_count` and `trg_count` paths.
- `ARG_W`, default 32: width of the step-count argument.

Ports:
- `clk_in`  in  1: free-running system clock (ungated side of `clk_count_stop`).
- `rst`  in  1: synchronous reset, active-high.
- `cmd_valid`  in  1: command present.
- `cmd_ready`  out  1: command accepted on the edge where `cmd_valid & cmd_ready`.
- `cmd_op`  in  2: command code: 00 HALT, 01 RUN, 10 STEP, 11 CLEAR.
- `cmd_arg`  in  ARG_W: step count N (STEP only).
- `match`  in  1: from `clk_count_stop`; high when the gated clock has reached `trg_count`.
- `active`  out  1: to `clk_count_stop`.
- `trg_count`  out  CNT_W: to `clk_count_stop`; absolute cycle target.
- `cycle_count`  out  CNT_W: executed gated-clock cycles.
- `halted`  out  1: high in HALT.
- `step_done`  out  1: one-cycle pulse when a STEP or HALT request completes.

## Operation
- States: FREE, STEP, HALT. Reset enters FREE.
- Reset values: `active`=0, `trg_count`=0, `cycle_count`=0, `cmd_ready`=1, `halted`=0, `step_done`=0.
- FREE:
  - `active`=0; `cycle_count` increments every edge; `match` is ignored.
  - HALT: `trg_count` <= `cycle_count`+1, `active` <= 1, go to STEP.
  - STEP: `trg_count` <= `cycle_count`+N, `active` <= 1, go to STEP.
  - RUN and CLEAR are consumed with no effect.
- STEP:
  - `cmd_ready`=0.
  - Each edge with `match`=0: `cycle_count` increments.
  - Edge with `match`=1: no increment; go to HALT; `step_done` pulses for one cycle.
- HALT:
  - `active`=1; `trg_count` held; `cycle_count` held; `halted`=1.
  - STEP with N>0: `trg_count` <= `trg_count`+N, go to STEP.
  - STEP with N=0: stay in HALT; `step_done` pulses on the next edge.
  - RUN: `active` <= 0, go to FREE.
  - CLEAR: `cycle_count` <= 0, `trg_count` <= 0; stay in HALT.
  - HALT: consumed, no effect.
- Arithmetic: all additions are modulo 2^CNT_W. N is zero-extended to CNT_W. Wrap-around is not flagged.
- `rst` mid-STEP: immediately returns to FREE with reset values. The next edge has `active`=0, so the downstream clock resumes.
- `cmd_valid` held while `cmd_ready`=0: the command is not consumed. It is accepted on the first edge after entering HALT.

## Timing
- All outputs are registered and update on the accepting edge; command-to-`active` latency is 1 cycle.
- `step_done` and `halted` both assert on the edge after `match` is first sampled high in STEP.
- The handshake is single-cycle. `cmd_ready` is combinational from state only, never from `cmd_valid`.
- In STEP, a `match` already high on the first STEP cycle (target already reached) completes on that edge with no increment.

## Configuration
- `CLK_STEP_BRK_EN`, when defined:
  - Adds ports `brk_en` (in, 1), `brk_count` (in, CNT_W) and `brk_hit` (out, 1, reset 0).
  - In FREE, with `brk_en`=1 and `cycle_count`==`brk_count`-1, the controller behaves as if HALT were accepted on that edge.
  - On completion, `brk_hit` pulses together with `step_done`.
  - An explicit command on the same edge takes priority.
- Undefined: these ports and the breakpoint logic are absent. All behaviour above is unchanged.

## Test plan
- Reset, then 10 idle cycles -> `active`=0, `cycle_count`=10, `halted`=0, `cmd_ready`=1.
- From FREE at `cycle_count`=10, issue HALT; model `match`=1 when the gated count reaches `trg_count` -> `trg_count`=11, `step_done` pulses once, `halted`=1, `cycle_count`=11.
- In HALT, STEP N=5 -> `trg_count`=16. `cmd_ready`=0 until HALT, then `cycle_count`=16 and one `step_done` pulse. Then STEP N=0 -> state unchanged, `step_done` pulses on the next edge.
- STEP with `trg_count`=2^64-3 and N=5 -> `trg_count`=2 (wrap), completes normally. CLEAR in HALT -> `trg_count`=0, `cycle_count`=0.
- Assert `rst` two cycles into a STEP of N=100 -> the following edge has `active`=0, `trg_count`=0, `cycle_count`=0, state FREE. A RUN held during STEP is accepted on the first HALT cycle -> `active`=0 next edge.
- With `CLK_STEP_BRK_EN`: `brk_en`=1, `brk_count`=20 from reset -> halts with `cycle_count`=20, `brk_hit` and `step_done` pulse together. With `brk_en`=0 -> no halt.
